// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - memory-stage load/store unit driving a byte-serial shared RAM port
module mem_lsu #(
    parameter int ADDR_WIDTH  = 32,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [3:0]            op_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           store_data_i,
    input  logic [31:0]           rd_data_i,
    input  logic [4:0]            rd_addr_i,
    input  logic                  rd_enable_i,
    output logic [31:0]           rd_data_o,
    output logic [4:0]            rd_addr_o,
    output logic                  rd_enable_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [7:0]            ram_dout_o,
    input  logic [7:0]            ram_din_i
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_XFER  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [3:0]            op_q;
    logic [31:0]           sdata;
    logic [2:0]            n_q;
    logic [2:0]            k;
    logic [31:0]           asm_q;
    logic                  sr_valid [RAM_LATENCY];
    logic [1:0]            sr_idx   [RAM_LATENCY];

    function automatic logic [2:0] size_of(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: size_of = 3'd1;
            OP_LH, OP_LHU, OP_SH: size_of = 3'd2;
            OP_LW, OP_SW:         size_of = 3'd4;
            default:              size_of = 3'd0;
        endcase
    endfunction

    logic in_is_mem;
    logic is_store_q;
    logic xfer;
    logic beat_fire;
    logic last_beat;
    logic drain_busy;
    logic [31:0] load_result;

    assign in_is_mem  = (size_of(op_i) != 3'd0);
    assign is_store_q = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);
    assign xfer       = (state == S_XFER) && !rst;
    assign beat_fire  = xfer && mem_gnt_i;
    assign last_beat  = (k == n_q - 3'd1);

    // Entries still travelling behind the one that exits this cycle.
    always_comb begin
        drain_busy = 1'b0;
        for (int i = 0; i < RAM_LATENCY - 1; i++) begin
            drain_busy = drain_busy | sr_valid[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAM_LATENCY; i++) begin
                sr_valid[i] <= 1'b0;
                sr_idx[i]   <= 2'd0;
            end
        end else begin
            sr_valid[0] <= beat_fire && !is_store_q;
            sr_idx[0]   <= k[1:0];
            for (int i = 1; i < RAM_LATENCY; i++) begin
                sr_valid[i] <= sr_valid[i-1];
                sr_idx[i]   <= sr_idx[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            base_addr <= '0;
            op_q      <= 4'd0;
            sdata     <= 32'd0;
            n_q       <= 3'd0;
            k         <= 3'd0;
            asm_q     <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid_i && in_is_mem) begin
                        base_addr <= addr_i;
                        op_q      <= op_i;
                        sdata     <= store_data_i;
                        n_q       <= size_of(op_i);
                        k         <= 3'd0;
                        asm_q     <= 32'd0;
                        state     <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (mem_gnt_i) begin
                        k <= k + 3'd1;
                        if (last_beat) begin
                            state <= is_store_q ? S_DONE : S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!drain_busy) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (sr_valid[RAM_LATENCY-1]) begin
                asm_q[{sr_idx[RAM_LATENCY-1], 3'b000} +: 8] <= ram_din_i;
            end
        end
    end

    always_comb begin
        case (op_q)
            OP_LB:   load_result = {{24{asm_q[7]}}, asm_q[7:0]};
            OP_LH:   load_result = {{16{asm_q[15]}}, asm_q[15:0]};
            OP_LBU:  load_result = {24'd0, asm_q[7:0]};
            OP_LHU:  load_result = {16'd0, asm_q[15:0]};
            default: load_result = asm_q;
        endcase
    end

    always_comb begin
        rd_data_o = 32'd0;
        if (!rst) begin
            case (state)
                S_IDLE:  rd_data_o = (valid_i && in_is_mem) ? 32'd0 : rd_data_i;
                S_DONE:  rd_data_o = is_store_q ? rd_data_i : load_result;
                default: rd_data_o = 32'd0;
            endcase
        end
    end

    assign stall_o     = !rst && (((state == S_IDLE) && valid_i && in_is_mem) ||
                                  (state == S_XFER) || (state == S_DRAIN));
    assign rd_addr_o   = rd_addr_i;
    assign rd_enable_o = rd_enable_i;
    assign mem_req_o   = xfer;
    assign ram_we_o    = beat_fire && is_store_q;
    assign ram_addr_o  = xfer ? base_addr + {{(ADDR_WIDTH-3){1'b0}}, k} : '0;
    assign ram_dout_o  = (xfer && is_store_q) ? sdata[{k[1:0], 3'b000} +: 8] : 8'd0;
endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - scoreboard bench for mem_lsu with a byte RAM model and reference memory
module tb_mem_lsu;
    localparam int AW  = 32;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic [3:0]    op_i;
    logic [AW-1:0] addr_i;
    logic [31:0]   store_data_i;
    logic [31:0]   rd_data_i;
    logic [4:0]    rd_addr_i;
    logic          rd_enable_i;
    logic [31:0]   rd_data_o;
    logic [4:0]    rd_addr_o;
    logic          rd_enable_o;
    logic          stall_o;
    logic          mem_req_o;
    logic          mem_gnt_i;
    logic [AW-1:0] ram_addr_o;
    logic          ram_we_o;
    logic [7:0]    ram_dout_o;
    logic [7:0]    ram_din_i = 8'd0;

    mem_lsu #(.ADDR_WIDTH(AW), .RAM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .addr_i(addr_i),
        .store_data_i(store_data_i), .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i),
        .rd_enable_i(rd_enable_i), .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o),
        .rd_enable_o(rd_enable_o), .stall_o(stall_o), .mem_req_o(mem_req_o),
        .mem_gnt_i(mem_gnt_i), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o),
        .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic we; logic [7:0] data; } beat_t;
    typedef struct { logic [31:0] data; logic [4:0] rda; logic rde; int lat; } ret_t;

    beat_t beat_q[$];
    ret_t  ret_q[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    logic [7:0] ram     [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic int size_of(input logic [3:0] op);
        if (op inside {4'd1, 4'd4, 4'd6}) return 1;
        if (op inside {4'd2, 4'd5, 4'd7}) return 2;
        if (op inside {4'd3, 4'd8}) return 4;
        return 0;
    endfunction

    // Little-endian gather followed by the architectural extension rule.
    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a);
        logic [31:0] w;
        w = {ref_rd(a + 3), ref_rd(a + 2), ref_rd(a + 1), ref_rd(a)};
        case (op)
            4'd1:    return 32'($signed(w[7:0]));
            4'd2:    return 32'($signed(w[15:0]));
            4'd4:    return 32'(w[7:0]);
            4'd5:    return 32'(w[15:0]);
            default: return w;
        endcase
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        ram[a]     = d;
        ref_mem[a] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // RAM model: capture granted beats at mid-cycle, return read bytes LAT cycles later.
    logic [7:0] pipe_d [LAT];
    logic       iss_v;
    logic [7:0] iss_d;
    always begin
        @(negedge clk);
        iss_v = 1'b0;
        iss_d = 8'd0;
        if (!rst && mem_req_o && mem_gnt_i) begin
            if (ram_we_o) ram[ram_addr_o] = ram_dout_o;
            else begin
                iss_v = 1'b1;
                iss_d = ram_rd(ram_addr_o);
            end
        end
        @(posedge clk);
        #1;
        for (int i = LAT - 1; i > 0; i--) pipe_d[i] = pipe_d[i-1];
        pipe_d[0] = iss_v ? iss_d : 8'($urandom);
        ram_din_i = pipe_d[LAT-1];
    end

    // Monitor: beats and retirements are popped from the scoreboard as they appear.
    bit    busy  = 1'b0;
    int    start = 0;
    beat_t eb;
    ret_t  er;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            busy = 1'b0;
        end else begin
            if (mem_req_o) chk("req_with_pending_beat", 32'(beat_q.size() != 0), 32'd1);
            if (mem_req_o && !mem_gnt_i) chk("we_without_gnt", 32'(ram_we_o), 32'd0);
            if (mem_req_o && mem_gnt_i && beat_q.size() != 0) begin
                eb = beat_q.pop_front();
                chk("beat_addr", ram_addr_o, eb.addr);
                chk("beat_we", 32'(ram_we_o), 32'(eb.we));
                if (eb.we) chk("beat_data", 32'(ram_dout_o), 32'(eb.data));
            end
            if (valid_i && !busy) begin
                busy  = 1'b1;
                start = cyc;
            end
            if (valid_i && !stall_o) begin
                busy = 1'b0;
                chk("retire_expected", 32'(ret_q.size() != 0), 32'd1);
                if (ret_q.size() != 0) begin
                    er = ret_q.pop_front();
                    chk("rd_data", rd_data_o, er.data);
                    chk("rd_addr", 32'(rd_addr_o), 32'(er.rda));
                    chk("rd_enable", 32'(rd_enable_o), 32'(er.rde));
                    chk("latency", 32'(cyc - start), 32'(er.lat));
                end
            end else if (busy && (cyc - start > 64)) begin
                chk("stall_timeout", 32'(cyc - start), 32'd64);
                busy = 1'b0;
            end
        end
    end

    // Issues one op starting in the current cycle; returns at the start of the cycle after retirement.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rdd, input logic [4:0] rda, input logic rde,
                          input bit rnd_gnt, input int drop);
        int   n;
        int   got;
        int   last;
        bit   g[$];
        bit   st;
        ret_t r;
        n    = size_of(op);
        st   = (op >= 4'd6) && (n != 0);
        got  = 0;
        last = 0;
        valid_i = 1'b1; op_i = op; addr_i = a; store_data_i = sd;
        rd_data_i = rdd; rd_addr_i = rda; rd_enable_i = rde;
        mem_gnt_i = 1'($urandom);
        r.rda = rda;
        r.rde = rde;
        if (n == 0) begin
            r.data = rdd;
            r.lat  = 0;
            ret_q.push_back(r);
            step();
            return;
        end
        for (int c = 1; got < n; c++) begin
            bit gg;
            gg = rnd_gnt ? ($urandom_range(0, 3) != 0) : (c != drop);
            g.push_back(gg);
            if (gg) begin
                got++;
                last = c;
            end
        end
        r.data = st ? rdd : ref_load(op, a);
        for (int i = 0; i < n; i++) begin
            beat_q.push_back('{addr: a + 32'(i), we: st, data: st ? sd[8*i +: 8] : 8'd0});
            if (st) ref_mem[a + 32'(i)] = sd[8*i +: 8];
        end
        r.lat = last + (st ? 0 : LAT) + 1;
        ret_q.push_back(r);
        for (int c = 1; c <= r.lat; c++) begin
            step();
            mem_gnt_i = (c <= g.size()) ? g[c-1] : 1'($urandom);
        end
        step();
    endtask

    task automatic idle(input int cycles);
        valid_i   = 1'b0;
        op_i      = 4'($urandom);
        rd_data_i = $urandom;
        mem_gnt_i = 1'($urandom);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("idle_passthru", rd_data_o, rd_data_i);
            chk("idle_stall", 32'(stall_o), 32'd0);
            step();
        end
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; op_i = 4'd0; addr_i = '0; store_data_i = 32'd0;
        rd_data_i = 32'd0; rd_addr_i = 5'd0; rd_enable_i = 1'b0; mem_gnt_i = 1'b0;
        step();
        step();
        valid_i = 1'b1; op_i = 4'd3; rd_data_i = 32'h1234_5678; mem_gnt_i = 1'b1;
        @(negedge clk);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_rd_data", rd_data_o, 32'd0);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_we", 32'(ram_we_o), 32'd0);
        chk("rst_addr", ram_addr_o, 32'd0);
        chk("rst_dout", 32'(ram_dout_o), 32'd0);
        step();
        rst = 1'b0;
        idle(2);

        poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
        run_op(4'd3, 32'h100, 32'd0, 32'h0, 5'd3, 1'b1, 1'b0, -1);
        poke(32'h200, 8'h80);
        run_op(4'd1, 32'h200, 32'd0, 32'h0, 5'd4, 1'b1, 1'b0, -1);
        run_op(4'd4, 32'h200, 32'd0, 32'h0, 5'd5, 1'b1, 1'b0, -1);
        run_op(4'd7, 32'h3FF, 32'h0000_BEEF, 32'hCAFE_0001, 5'd6, 1'b0, 1'b0, 2);
        poke(32'h10, 8'h34); poke(32'h11, 8'h92);
        run_op(4'd5, 32'h10, 32'd0, 32'h0, 5'd7, 1'b1, 1'b0, -1);
        run_op(4'd0, 32'h0, 32'd0, 32'hDEAD_BEEF, 5'd8, 1'b1, 1'b0, -1);
        run_op(4'd12, 32'h0, 32'd0, 32'h0BAD_F00D, 5'd9, 1'b0, 1'b0, -1);
        idle(1);

        // Reset lands on cycle 2 of a word load that has issued only its first beat.
        valid_i = 1'b1; op_i = 4'd3; addr_i = 32'h100; mem_gnt_i = 1'b0;
        beat_q.push_back('{addr: 32'h100, we: 1'b0, data: 8'd0});
        step();
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_stall", 32'(stall_o), 32'd0);
        chk("midrst_rd_data", rd_data_o, 32'd0);
        step();
        rst = 1'b0; valid_i = 1'b0; rd_data_i = 32'h5555_AAAA;
        @(negedge clk);
        chk("postrst_req", 32'(mem_req_o), 32'd0);
        chk("postrst_we", 32'(ram_we_o), 32'd0);
        chk("postrst_stall", 32'(stall_o), 32'd0);
        chk("postrst_idle", rd_data_o, 32'h5555_AAAA);
        step();
        poke(32'h100, 8'hA1); poke(32'h101, 8'hB2); poke(32'h102, 8'hC3); poke(32'h103, 8'hD4);
        run_op(4'd3, 32'h100, 32'd0, 32'h0, 5'd10, 1'b1, 1'b0, -1);

        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                            : 32'h300 + $urandom_range(0, 63);
            run_op(4'($urandom_range(0, 15)), a, $urandom, $urandom, 5'($urandom),
                   1'($urandom), 1'b1, -1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        idle(LAT + 3);
        chk("ret_queue_drained", 32'(ret_q.size()), 32'd0);
        chk("beat_queue_drained", 32'(beat_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
